// File: rtl/e_gpu_host_mem_pkg.sv
// Shared e-GPU package.
// Purpose: OBI bus widths and the default host memory map, used by the host
// memory, its bus interfaces and anything that addresses kernel buffers.
// Ports: none (package only).
package e_gpu_pkg;

  localparam int unsigned OBI_ADDR_W = 32;
  localparam int unsigned OBI_DATA_W = 32;
  localparam int unsigned OBI_BE_W   = OBI_DATA_W / 8;

  // Default host memory map (byte addresses).
  localparam logic [31:0] HOST_MEM_SIZE = 32'h0005_0000;
  localparam logic [31:0] KERNEL_ARGS   = 32'h0002_0000;
  localparam logic [31:0] KERNEL_DATA   = 32'h0003_0000;

endpackage

// File: rtl/e_gpu_host_mem_if.sv
// OBI request/response bundles used between the e-GPU host-memory master
// and the host memory.
// obi_req_if: req, we, be, addr, wdata from master; gnt back from slave.
// obi_rsp_if: rvalid, rdata from slave to master.
interface obi_req_if;
  import e_gpu_pkg::*;

  logic                  req;
  logic                  we;
  logic [OBI_BE_W-1:0]   be;
  logic [OBI_ADDR_W-1:0] addr;
  logic [OBI_DATA_W-1:0] wdata;
  logic                  gnt;

  modport master (output req, output we, output be, output addr, output wdata, input gnt);
  modport slave  (input req, input we, input be, input addr, input wdata, output gnt);
endinterface

interface obi_rsp_if;
  import e_gpu_pkg::*;

  logic                  rvalid;
  logic [OBI_DATA_W-1:0] rdata;

  modport master (input rvalid, input rdata);
  modport slave  (output rvalid, output rdata);
endinterface

// File: rtl/e_gpu_host_mem.sv
// e_gpu_host_mem: word-organised host memory, OBI slave for the e-GPU
// host-memory master port.
// Ports:
//   clk_i        clock
//   rst_ni       asynchronous active-low reset (response path only)
//   host_mem_req OBI request bundle (slave side); gnt = req, no back-pressure
//   host_mem_rsp OBI response bundle (slave side); rvalid one cycle after
//                each accepted request, rdata = read word or 0 for writes
// mem_array is loaded and dumped hierarchically and is never touched by
// reset, so code/args/data survive a reset of the GPU.
module e_gpu_host_mem
  import e_gpu_pkg::*;
#(
  parameter int unsigned MEM_SIZE_WORD = 32'h0001_4000,
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned DATA_WIDTH    = 32
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  obi_req_if.slave  host_mem_req,
  obi_rsp_if.slave  host_mem_rsp
);

  localparam int unsigned IDX_W = $clog2(MEM_SIZE_WORD);

  logic [DATA_WIDTH-1:0] mem_array [0:MEM_SIZE_WORD-1];

  logic                  accept;
  logic                  in_range;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [IDX_W-1:0]      mem_idx;
  logic                  rvalid_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;

  // Byte-lane merge: lanes with be set take new data, others keep old data.
  function automatic logic [DATA_WIDTH-1:0] be_merge(
    input logic [DATA_WIDTH-1:0]   old_w,
    input logic [DATA_WIDTH-1:0]   new_w,
    input logic [DATA_WIDTH/8-1:0] be
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_w;
    for (int b = 0; b < DATA_WIDTH / 8; b++) begin
      if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  assign accept   = host_mem_req.req;
  assign host_mem_req.gnt = host_mem_req.req;

  // Byte address to word index; the low two address bits are ignored.
  assign word_idx = {2'b00, host_mem_req.addr[ADDR_WIDTH-1:2]};
  assign in_range = (word_idx < ADDR_WIDTH'(MEM_SIZE_WORD));
  assign mem_idx  = word_idx[IDX_W-1:0];

  // Discarded address bits, kept visible so they are not flagged as dangling.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{host_mem_req.addr[1:0], word_idx[ADDR_WIDTH-1:IDX_W]};

  // Storage has no reset so backdoor contents persist across rst_ni.
  // Out-of-range writes are silently dropped.
  always_ff @(posedge clk_i) begin
    if (accept && host_mem_req.we && in_range) begin
      mem_array[mem_idx] <= be_merge(mem_array[mem_idx], host_mem_req.wdata,
                                     host_mem_req.be);
    end
  end

  // Response path. The read samples the array before any same-edge write
  // lands (non-blocking update above). Writes and out-of-range reads return 0.
  // rdata only updates on accepted requests, so it holds while rvalid is low.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_reg <= 1'b0;
      rdata_reg  <= '0;
    end else begin
      rvalid_reg <= accept;
      if (accept) begin
        rdata_reg <= (!host_mem_req.we && in_range) ? mem_array[mem_idx] : '0;
      end
    end
  end

  assign host_mem_rsp.rvalid = rvalid_reg;
  assign host_mem_rsp.rdata  = rdata_reg;

endmodule

// File: tb/tb_e_gpu_host_mem.sv
// Testbench for e_gpu_host_mem: table-driven back-to-back OBI traffic with a
// response scoreboard, plus hand-written reset/idle sequences.
module tb_e_gpu_host_mem;
  import e_gpu_pkg::*;

  logic clk;
  logic rst_ni;

  obi_req_if req_if ();
  obi_rsp_if rsp_if ();

  e_gpu_host_mem dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .host_mem_req (req_if),
    .host_mem_rsp (rsp_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [15];

  // Response monitor, sampling mid-cycle away from the active edge.
  always @(negedge clk) begin
    if (rst_ni) begin
      if (req_if.req) check("gnt", {31'b0, req_if.gnt}, 32'h1);
      if (rsp_if.rvalid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rvalid", 32'h1, 32'h0);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          $display("rsp rdata=%08h expected=%08h", rsp_if.rdata, e);
          check("rdata", rsp_if.rdata, e);
        end
      end
    end
  end

  task automatic drive(input logic we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata);
    @(posedge clk);
    #1;
    req_if.req   = 1'b1;
    req_if.we    = we;
    req_if.be    = be;
    req_if.addr  = addr;
    req_if.wdata = wdata;
    exp_q.push_back(exp_rdata);
    $display("req we=%0d be=%04b addr=%08h wdata=%08h", we, be, addr, wdata);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    req_if.req = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    check("drain_timeout", exp_q.size(), 32'h0);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 4'hF, 32'h0002_0000, 32'h0, 32'hDEADBEEF};
    vecs[1]  = '{1'b1, 4'hF, 32'h0003_0004, 32'h11223344, 32'h0};
    vecs[2]  = '{1'b0, 4'hF, 32'h0003_0004, 32'h0, 32'h11223344};
    vecs[3]  = '{1'b1, 4'h5, 32'h0003_0004, 32'hAABBCCDD, 32'h0};
    vecs[4]  = '{1'b0, 4'hF, 32'h0003_0004, 32'h0, 32'h11BB33DD};
    vecs[5]  = '{1'b0, 4'hF, 32'h0000_0000, 32'h0, 32'h1};
    vecs[6]  = '{1'b0, 4'hF, 32'h0000_0004, 32'h0, 32'h2};
    vecs[7]  = '{1'b0, 4'hF, 32'h0000_0008, 32'h0, 32'h3};
    vecs[8]  = '{1'b1, 4'hF, 32'h0005_0000, 32'hFFFFFFFF, 32'h0};
    vecs[9]  = '{1'b0, 4'hF, 32'h0005_0000, 32'h0, 32'h0};
    vecs[10] = '{1'b0, 4'hF, 32'h0004_FFFC, 32'h0, 32'h5A5A5A5A};
    vecs[11] = '{1'b1, 4'h1, 32'h0003_0007, 32'h00000099, 32'h0};
    vecs[12] = '{1'b0, 4'hF, 32'h0003_0006, 32'h0, 32'h11BB3399};
    vecs[13] = '{1'b1, 4'h0, 32'h0003_0004, 32'hFFFFFFFF, 32'h0};
    vecs[14] = '{1'b0, 4'hF, 32'h0003_0004, 32'h0, 32'h11BB3399};

    rst_ni       = 1'b0;
    req_if.req   = 1'b0;
    req_if.we    = 1'b0;
    req_if.be    = 4'h0;
    req_if.addr  = 32'h0;
    req_if.wdata = 32'h0;

    // Backdoor preload while in reset.
    #2;
    dut.mem_array[32'h8000]  <= 32'hDEADBEEF;
    dut.mem_array[0]         <= 32'h1;
    dut.mem_array[1]         <= 32'h2;
    dut.mem_array[2]         <= 32'h3;
    dut.mem_array[32'h13FFF] <= 32'h5A5A5A5A;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rvalid", {31'b0, rsp_if.rvalid}, 32'h0);
    check("reset_rdata", rsp_if.rdata, 32'h0);
    check("reset_gnt_idle", {31'b0, req_if.gnt}, 32'h0);
    rst_ni = 1'b1;

    // Table: back-to-back, one request per cycle.
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);
    end
    idle();
    drain();

    // Idle: rvalid low, rdata holds its last value.
    check("idle_rvalid", {31'b0, rsp_if.rvalid}, 32'h0);
    check("idle_rdata_hold", rsp_if.rdata, 32'h11BB3399);
    check("oor_last_word_intact", dut.mem_array[32'h13FFF], 32'h5A5A5A5A);

    // req low with write-like fields must not touch memory.
    @(posedge clk);
    #1;
    req_if.we    = 1'b1;
    req_if.be    = 4'hF;
    req_if.addr  = 32'h0003_0004;
    req_if.wdata = 32'h0;
    repeat (2) @(posedge clk);
    drive(1'b0, 4'hF, 32'h0003_0004, 32'h0, 32'h11BB3399);
    idle();
    drain();

    // Reset in the cycle after a read is accepted.
    drive(1'b0, 4'hF, 32'h0002_0000, 32'h0, 32'hDEADBEEF);
    idle();
    #1;
    check("pre_reset_rvalid", {31'b0, rsp_if.rvalid}, 32'h1);
    rst_ni = 1'b0;
    #1;
    check("async_reset_rvalid", {31'b0, rsp_if.rvalid}, 32'h0);
    check("async_reset_rdata", rsp_if.rdata, 32'h0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    drive(1'b0, 4'hF, 32'h0002_0000, 32'h0, 32'hDEADBEEF);
    drive(1'b0, 4'hF, 32'h0003_0004, 32'h0, 32'h11BB3399);
    idle();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
